// File: rtl/countdown_ctrl_if.sv
// Key-pulse input and display/status outputs of the countdown timer controller.
// The master modport is the key/display side; the slave modport is countdown_ctrl.
interface countdown_ctrl_if;
    logic [3:0] key_pulse;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic [1:0] state_out;
    logic       done_pulse;
    logic       alarm;

    modport master (
        output key_pulse,
        input  min_out,
        input  sec_out,
        input  state_out,
        input  done_pulse,
        input  alarm
    );

    modport slave (
        input  key_pulse,
        output min_out,
        output sec_out,
        output state_out,
        output done_pulse,
        output alarm
    );
endinterface

// File: rtl/countdown_ctrl.sv
// mm:ss countdown controller driven by debounced key pulses, with its own 1 Hz prescaler.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN restores the last started preset on clear/done exit.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned MIN_MAX  = 99
) (
    input  logic             clk,
    input  logic             rst,
    countdown_ctrl_if.slave  bus
);

    localparam int unsigned PS_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MIN_W = 7;
    localparam int unsigned SEC_W = 6;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0] SEC_TOP  = SEC_W'(59);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MIN_W-1:0]   r_min;
    logic [MIN_W-1:0]   w_min_nxt;
    logic [SEC_W-1:0]   r_sec;
    logic [SEC_W-1:0]   w_sec_nxt;
    logic [PS_W-1:0]    r_ps;
    logic [PS_W-1:0]    w_ps_nxt;
    logic               r_done_pulse;
    logic               w_done_nxt;
    logic               r_alarm;
    logic               w_alarm_nxt;

    logic               w_key_start;
    logic               w_key_clear;
    logic               w_key_min;
    logic               w_key_sec;
    logic               w_any_key;
    logic               w_tick;
    logic               w_time_zero;
    logic [MIN_W-1:0]   w_dec_min;
    logic [SEC_W-1:0]   w_dec_sec;
    logic               w_dec_zero;
    logic [MIN_W-1:0]   w_reload_min;
    logic [SEC_W-1:0]   w_reload_sec;

    assign w_key_start = bus.key_pulse[0];
    assign w_key_clear = bus.key_pulse[1];
    assign w_key_min   = bus.key_pulse[2];
    assign w_key_sec   = bus.key_pulse[3];
    assign w_any_key   = |bus.key_pulse;

    assign w_tick      = (r_state == ST_RUN) && (r_ps == PS_LAST);
    assign w_time_zero = (r_min == '0) && (r_sec == '0);

    // One-second decrement with borrow from minutes when seconds are exhausted.
    always_comb begin
        w_dec_min  = r_min;
        w_dec_sec  = r_sec;
        if (r_sec != '0) begin
            w_dec_sec = r_sec - SEC_W'(1);
        end else begin
            w_dec_min = r_min - MIN_W'(1);
            w_dec_sec = SEC_TOP;
        end
        w_dec_zero = (w_dec_min == '0) && (w_dec_sec == '0);
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [MIN_W-1:0] r_pre_min;
    logic [SEC_W-1:0] r_pre_sec;

    // Preset is captured on every IDLE->RUN start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_min <= '0;
            r_pre_sec <= '0;
        end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)) begin
            r_pre_min <= r_min;
            r_pre_sec <= r_sec;
        end
    end

    assign w_reload_min = r_pre_min;
    assign w_reload_sec = r_pre_sec;
`else
    assign w_reload_min = '0;
    assign w_reload_sec = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_min        <= '0;
            r_sec        <= '0;
            r_ps         <= '0;
            r_done_pulse <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_min        <= w_min_nxt;
            r_sec        <= w_sec_nxt;
            r_ps         <= w_ps_nxt;
            r_done_pulse <= w_done_nxt;
            r_alarm      <= w_alarm_nxt;
        end
    end

    // Next-state and next-time logic; key priority is clear > start > add.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_ps_nxt    = r_ps;

        case (r_state)
            ST_IDLE: begin
                if (w_key_clear) begin
                    w_min_nxt = '0;
                    w_sec_nxt = '0;
                end else if (w_key_start) begin
                    if (!w_time_zero) begin
                        w_state_nxt = ST_RUN;
                        w_ps_nxt    = '0;
                    end
                end else begin
                    if (w_key_min) begin
                        w_min_nxt = (r_min == MIN_TOP) ? '0 : r_min + MIN_W'(1);
                    end
                    if (w_key_sec) begin
                        w_sec_nxt = (r_sec == SEC_TOP) ? '0 : r_sec + SEC_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (w_key_clear) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = w_reload_min;
                    w_sec_nxt   = w_reload_sec;
                end else if (w_key_start) begin
                    // Pausing freezes the prescaler, even on a tick cycle.
                    w_state_nxt = ST_PAUSE;
                end else if (w_tick) begin
                    w_ps_nxt  = '0;
                    w_min_nxt = w_dec_min;
                    w_sec_nxt = w_dec_sec;
                    if (w_dec_zero) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_ps_nxt = r_ps + PS_W'(1);
                end
            end

            ST_PAUSE: begin
                if (w_key_clear) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = w_reload_min;
                    w_sec_nxt   = w_reload_sec;
                end else if (w_key_start) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DONE: begin
                if (w_any_key) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = w_reload_min;
                    w_sec_nxt   = w_reload_sec;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_min_nxt   = '0;
                w_sec_nxt   = '0;
                w_ps_nxt    = '0;
            end
        endcase
    end

    assign w_done_nxt  = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    assign w_alarm_nxt = (w_state_nxt == ST_DONE);

    assign bus.min_out    = r_min;
    assign bus.sec_out    = r_sec;
    assign bus.state_out  = r_state;
    assign bus.done_pulse = r_done_pulse;
    assign bus.alarm      = r_alarm;

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Countdown timer controller directly downstream of the multi-key debouncer. It consumes the debouncer's one-cycle key pulses and lets the user set a mm:ss preset, then start, pause and clear the countdown. It generates its own 1 Hz tick from clk and drives binary minutes/seconds to the display stage, plus done and alarm indications.

Parameters:
TICK_DIV, 10_000_000, clk cycles per countdown second (10 MHz clk gives 1 Hz); minimum 2
MIN_MAX, 99, maximum settable minutes value; must be ≤ 127

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
key_pulse  input  4  one-cycle key pulses from debouncer: [0]=start/pause, [1]=clear, [2]=add minute, [3]=add second
min_out  output  7  current minutes, binary, 0..MIN_MAX
sec_out  output  6  current seconds, binary, 0..59
state_out  output  2  FSM state: 0=IDLE, 1=RUN, 2=PAUSE, 3=DONE
done_pulse  output  1  one-cycle pulse on the cycle DONE is entered
alarm  output  1  high while in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs and state are registered.
- Reset values: state=IDLE, min_out=0, sec_out=0, done_pulse=0, alarm=0, prescaler=0.
- Prescaler: $clog2(TICK_DIV) bits. It increments only in RUN. When prescaler==TICK_DIV-1 in RUN, a tick occurs and the prescaler returns to 0. It holds its value in PAUSE and clears to 0 on every entry to RUN from IDLE.
- Key priority within a cycle: clear > start > add keys. Add minute and add second may both apply in the same cycle.
- IDLE:
  - add minute: min = (min==MIN_MAX) ? 0 : min+1.
  - add second: sec = (sec==59) ? 0 : sec+1. No carry into minutes.
  - start: if time ≠ 00:00, go to RUN and clear the prescaler. If time = 00:00, ignore.
  - clear: min=sec=0.
- RUN:
  - tick: if sec>0 then sec−1; otherwise min−1 and sec=59.
  - If the decrement yields 00:00, go to DONE on the same edge and assert done_pulse for 1 cycle.
  - start: go to PAUSE. A start and a tick in the same cycle give PAUSE with no decrement and the prescaler held.
  - clear: go to IDLE with time=0 (see optional feature).
  - Add keys are ignored.
- PAUSE:
  - start: resume RUN from the held prescaler value.
  - clear: go to IDLE with time=0.
  - Add keys are ignored.
- DONE: alarm=1 and time stays 00:00. Any key pulse goes to IDLE and deasserts alarm on the next cycle.
- Latency: key pulse to updated outputs is 1 cycle. The first decrement comes exactly TICK_DIV cycles after the edge that enters RUN from IDLE.
- done_pulse is deasserted every cycle except the DONE entry cycle.
- Asynchronous reset during RUN, PAUSE or DONE returns immediately to the reset values.
- Unused state encodings recover to IDLE.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- When defined:
  - A preset register (7+6 bits, reset 0) captures min/sec on each IDLE→RUN transition.
  - clear in RUN/PAUSE, and any key in DONE, return to IDLE with min/sec restored to the preset.
  - clear in IDLE still zeroes time but leaves the preset unchanged.
- When undefined: no preset register; every exit to IDLE via clear or DONE leaves time at 00:00.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset, then 2× add minute and 3× add second → min_out=2, sec_out=3, state_out=0. Then 98 more add minute → min_out wraps to 0. 60× add second from 0 → sec_out=0 with no carry into minutes.
2. Set 00:02, start → state_out=1; sec_out=1 exactly 4 cycles after entry, 0 at 8 cycles. done_pulse high for exactly 1 cycle with state_out=3 and alarm=1. Then a key pulse → IDLE, alarm=0.
3. Set 01:00, start, wait 4 cycles → min_out=0, sec_out=59 (borrow path).
4. Start at 00:05, pause after 2 cycles, hold 10 cycles → sec_out stays 5. Resume → decrement occurs 2 cycles later (prescaler held).
5. Start with time 00:00 → stays IDLE. Start and add minute in the same cycle in IDLE at 00:01 → RUN, min_out=0 unchanged. Clear and start together in RUN → IDLE, time=0 (macro off) or preset (macro on).
6. Assert rst asynchronously mid-RUN between clk edges → outputs go to reset values before the next edge. With COUNTDOWN_AUTO_RELOAD_EN: set 03:10, run to DONE, key → min_out=3, sec_out=10.
